// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: single-outstanding command sequencer for the FPU datapath.
// Single-cycle units are sampled in their ISSUE cycle. Divider and sqrt get a
// start pulse, are waited on with a bounded counter, and are cancelled on timeout.
// Every command returns one response; irq pulses on abnormal responses.
module fpu_op_sequencer #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [1:0]  cmd_sub,
   input  logic [2:0]  cmd_frm,
   output logic [10:0] fpu_sel,
   output logic [1:0]  fpu_op,
   output logic [2:0]  fpu_frm,
   output logic [1:0]  fpu_start,
   output logic        fpu_cancel,
   input  logic [31:0] fpu_result,
   input  logic [4:0]  fpu_exc,
   input  logic        div_done,
   input  logic        sqrt_done,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [4:0]  rsp_exc,
   output logic        rsp_illegal,
   output logic        rsp_timeout,
   output logic        busy,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // Counter value in the last WAIT cycle before the abort edge.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   // Unit index beyond sqrt, or a sign-inject/compare with the reserved sub-op.
   function automatic logic cmd_is_illegal(input logic [3:0] op, input logic [1:0] sub);
      cmd_is_illegal = (op > 4'd10) || (((op == 4'd1) || (op == 4'd2)) && (sub == 2'd3));
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [1:0]  sub_q, sub_d;
   logic [2:0]  frm_q, frm_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] data_q, data_d;
   logic [4:0]  exc_q, exc_d;
   logic        illegal_q, illegal_d;
   logic        timeout_q, timeout_d;
   logic        cancel_q, cancel_d;
   logic        irq_q, irq_d;
   logic        done_match_s;

   // State and response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= 4'd0;
         sub_q     <= 2'd0;
         frm_q     <= 3'd0;
         cnt_q     <= 16'd0;
         data_q    <= 32'd0;
         exc_q     <= 5'd0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
         cancel_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         sub_q     <= sub_d;
         frm_q     <= frm_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         exc_q     <= exc_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
         cancel_q  <= cancel_d;
         irq_q     <= irq_d;
      end
   end

   // Next-state, command latch, wait counter and response capture.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      sub_d     = sub_q;
      frm_d     = frm_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      exc_d     = exc_q;
      illegal_d = illegal_q;
      timeout_d = timeout_q;
      cancel_d  = 1'b0;
      done_match_s = (op_q == 4'd9) ? div_done : sqrt_done;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d      = cmd_op;
               sub_d     = cmd_sub;
               frm_d     = cmd_frm;
               data_d    = 32'd0;
               exc_d     = 5'd0;
               timeout_d = 1'b0;
               if (cmd_is_illegal(cmd_op, cmd_sub)) begin
                  illegal_d = 1'b1;
                  state_d   = S_RESP;
               end else begin
                  illegal_d = 1'b0;
                  state_d   = S_ISSUE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            cnt_d = 16'd0;
            if ((op_q == 4'd9) || (op_q == 4'd10)) begin
               state_d = S_WAIT;
            end else begin
               data_d  = fpu_result;
               exc_d   = fpu_exc;
               state_d = S_RESP;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            if (done_match_s) begin
               // Completion takes priority over a coincident timeout.
               data_d  = fpu_result;
               exc_d   = fpu_exc;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               cancel_d  = 1'b1;
               timeout_d = 1'b1;
               data_d    = 32'd0;
               exc_d     = 5'd0;
               state_d   = S_RESP;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // irq is raised only on the transition into RESP, so it lasts one cycle.
      irq_d = (state_q != S_RESP) && (state_d == S_RESP) &&
              (illegal_d || timeout_d || (exc_d != 5'd0));
   end

   // Datapath controls and handshake outputs decoded from the current state.
   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b1;
      rsp_valid = 1'b0;
      fpu_sel   = 11'd0;
      fpu_op    = 2'd0;
      fpu_frm   = 3'd0;
      fpu_start = 2'b00;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         S_ISSUE: begin
            fpu_sel = 11'd1 << op_q;
            fpu_op  = sub_q;
            fpu_frm = frm_q;
            if (op_q == 4'd9) begin
               fpu_start = 2'b01;
            end else if (op_q == 4'd10) begin
               fpu_start = 2'b10;
            end else begin
               fpu_start = 2'b00;
            end
         end
         S_WAIT: begin
            fpu_sel = 11'd1 << op_q;
            fpu_op  = sub_q;
            fpu_frm = frm_q;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   assign fpu_cancel  = cancel_q;
   assign irq         = irq_q;
   assign rsp_data    = data_q;
   assign rsp_exc     = exc_q;
   assign rsp_illegal = illegal_q;
   assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer. Instance a uses the default TIMEOUT,
// instance b uses TIMEOUT=8. Expected responses are queued when a command is
// driven and compared when the DUT presents its response.
module tb_fpu_op_sequencer;

   typedef struct packed {
      logic [31:0] d;
      logic [4:0]  e;
      logic        il;
      logic        to;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, va, vb, rsp_ready, div_done, sqrt_done;
   logic [3:0]  cmd_op;
   logic [1:0]  cmd_sub;
   logic [2:0]  cmd_frm;
   logic [31:0] fpu_result;
   logic [4:0]  fpu_exc;

   logic        a_cmd_ready, a_fpu_cancel, a_rsp_valid, a_rsp_illegal, a_rsp_timeout, a_busy, a_irq;
   logic [10:0] a_fpu_sel;
   logic [1:0]  a_fpu_op, a_fpu_start;
   logic [2:0]  a_fpu_frm;
   logic [31:0] a_rsp_data;
   logic [4:0]  a_rsp_exc;

   logic        b_cmd_ready, b_fpu_cancel, b_rsp_valid, b_rsp_illegal, b_rsp_timeout, b_busy, b_irq;
   logic [10:0] b_fpu_sel;
   logic [1:0]  b_fpu_op, b_fpu_start;
   logic [2:0]  b_fpu_frm;
   logic [31:0] b_rsp_data;
   logic [4:0]  b_rsp_exc;

   rsp_t qa[$];
   rsp_t qb[$];
   int   nerr = 0;
   int   nchk = 0;

   fpu_op_sequencer dut_a (
      .clk(clk), .rst(rst), .cmd_valid(va), .cmd_ready(a_cmd_ready),
      .cmd_op(cmd_op), .cmd_sub(cmd_sub), .cmd_frm(cmd_frm),
      .fpu_sel(a_fpu_sel), .fpu_op(a_fpu_op), .fpu_frm(a_fpu_frm),
      .fpu_start(a_fpu_start), .fpu_cancel(a_fpu_cancel),
      .fpu_result(fpu_result), .fpu_exc(fpu_exc),
      .div_done(div_done), .sqrt_done(sqrt_done),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data),
      .rsp_exc(a_rsp_exc), .rsp_illegal(a_rsp_illegal), .rsp_timeout(a_rsp_timeout),
      .busy(a_busy), .irq(a_irq)
   );

   fpu_op_sequencer #(.TIMEOUT(8)) dut_b (
      .clk(clk), .rst(rst), .cmd_valid(vb), .cmd_ready(b_cmd_ready),
      .cmd_op(cmd_op), .cmd_sub(cmd_sub), .cmd_frm(cmd_frm),
      .fpu_sel(b_fpu_sel), .fpu_op(b_fpu_op), .fpu_frm(b_fpu_frm),
      .fpu_start(b_fpu_start), .fpu_cancel(b_fpu_cancel),
      .fpu_result(fpu_result), .fpu_exc(fpu_exc),
      .div_done(div_done), .sqrt_done(sqrt_done),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data),
      .rsp_exc(b_rsp_exc), .rsp_illegal(b_rsp_illegal), .rsp_timeout(b_rsp_timeout),
      .busy(b_busy), .irq(b_irq)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pop the oldest expected response of one instance and compare all fields.
   task automatic check_rsp(input bit use_b, input string tag);
      rsp_t e;
      rsp_t o;
      int   n;
      o = use_b ? {b_rsp_data, b_rsp_exc, b_rsp_illegal, b_rsp_timeout}
                : {a_rsp_data, a_rsp_exc, a_rsp_illegal, a_rsp_timeout};
      n = use_b ? qb.size() : qa.size();
      if (n == 0) begin
         nchk++;
         nerr++;
         $error("FAIL %s observed=response expected=none_queued", tag);
      end else begin
         e = use_b ? qb.pop_front() : qa.pop_front();
         chk({tag, "_data"},    o.d,          e.d);
         chk({tag, "_exc"},     32'(o.e),     32'(e.e));
         chk({tag, "_illegal"}, 32'(o.il),    32'(e.il));
         chk({tag, "_timeout"}, 32'(o.to),    32'(e.to));
      end
   endtask

   initial begin
      rst = 1'b1; va = 1'b0; vb = 1'b0; rsp_ready = 1'b1;
      div_done = 1'b0; sqrt_done = 1'b0;
      cmd_op = 4'd0; cmd_sub = 2'd0; cmd_frm = 3'd0;
      fpu_result = 32'd0; fpu_exc = 5'd0;
      repeat (3) step();
      chk("rst_sel",    32'(a_fpu_sel),   32'h0);
      chk("rst_busy",   32'(a_busy),      32'h0);
      chk("rst_rvalid", 32'(a_rsp_valid), 32'h0);
      chk("rst_irq",    32'(a_irq),       32'h0);
      rst = 1'b0;
      step();
      chk("rel_ready_a", 32'(a_cmd_ready), 32'h1);
      chk("rel_ready_b", 32'(b_cmd_ready), 32'h1);

      // Add: single-cycle unit 6.
      cmd_op = 4'd6; cmd_sub = 2'd0; cmd_frm = 3'd0; va = 1'b1;
      fpu_result = 32'h40400000; fpu_exc = 5'd0;
      qa.push_back('{32'h40400000, 5'd0, 1'b0, 1'b0});
      step();
      va = 1'b0;
      chk("add_sel_t1",    32'(a_fpu_sel),   32'h040);
      chk("add_rvalid_t1", 32'(a_rsp_valid), 32'h0);
      step();
      chk("add_sel_t2",    32'(a_fpu_sel),   32'h000);
      chk("add_rvalid_t2", 32'(a_rsp_valid), 32'h1);
      chk("add_irq",       32'(a_irq),       32'h0);
      check_rsp(1'b0, "add");
      step();
      chk("add_ready_t3",  32'(a_cmd_ready), 32'h1);

      // Divide: done at T+20, inexact flag, a stray sqrt_done ignored.
      cmd_op = 4'd9; va = 1'b1;
      fpu_result = 32'h3F000000; fpu_exc = 5'b00001;
      qa.push_back('{32'h3F000000, 5'b00001, 1'b0, 1'b0});
      step();
      va = 1'b0;
      chk("div_start_t1", 32'(a_fpu_start), 32'h1);
      chk("div_sel_t1",   32'(a_fpu_sel),   32'h200);
      for (int c = 2; c <= 20; c++) begin
         step();
         sqrt_done = (c == 10);
         div_done  = (c == 20);
         if (c == 2) chk("div_start_t2", 32'(a_fpu_start), 32'h0);
         chk("div_sel_wait",    32'(a_fpu_sel),   32'h200);
         chk("div_rvalid_wait", 32'(a_rsp_valid), 32'h0);
      end
      step();
      div_done = 1'b0;
      chk("div_rvalid_t21", 32'(a_rsp_valid),  32'h1);
      chk("div_irq_t21",    32'(a_irq),        32'h1);
      chk("div_cancel",     32'(a_fpu_cancel), 32'h0);
      check_rsp(1'b0, "div");
      step();
      chk("div_irq_t22", 32'(a_irq), 32'h0);

      // Timeout on the TIMEOUT=8 instance.
      cmd_op = 4'd10; vb = 1'b1;
      qb.push_back('{32'h0, 5'd0, 1'b0, 1'b1});
      step();
      vb = 1'b0;
      chk("to_start_t1", 32'(b_fpu_start), 32'h2);
      for (int c = 2; c <= 9; c++) begin
         step();
         chk("to_cancel_wait", 32'(b_fpu_cancel), 32'h0);
         chk("to_rvalid_wait", 32'(b_rsp_valid),  32'h0);
      end
      step();
      chk("to_cancel_t10", 32'(b_fpu_cancel), 32'h1);
      chk("to_rvalid_t10", 32'(b_rsp_valid),  32'h1);
      chk("to_irq_t10",    32'(b_irq),        32'h1);
      check_rsp(1'b1, "to");
      step();
      chk("to_cancel_t11", 32'(b_fpu_cancel), 32'h0);
      chk("to_irq_t11",    32'(b_irq),        32'h0);

      // Done on the abort edge: completion wins, no cancel.
      fpu_result = 32'h41000000; fpu_exc = 5'd0; vb = 1'b1;
      qb.push_back('{32'h41000000, 5'd0, 1'b0, 1'b0});
      step();
      vb = 1'b0;
      for (int c = 2; c <= 9; c++) begin
         step();
         sqrt_done = (c == 9);
      end
      step();
      sqrt_done = 1'b0;
      chk("race_rvalid", 32'(b_rsp_valid),  32'h1);
      chk("race_cancel", 32'(b_fpu_cancel), 32'h0);
      chk("race_irq",    32'(b_irq),        32'h0);
      chk("idle_a_done", 32'(a_rsp_valid),  32'h0);
      check_rsp(1'b1, "race");
      step();

      // Illegal commands: compare with reserved sub-op, and unit index 13.
      cmd_op = 4'd2; cmd_sub = 2'd3; va = 1'b1; fpu_result = 32'hFFFFFFFF;
      qa.push_back('{32'h0, 5'd0, 1'b1, 1'b0});
      step();
      va = 1'b0;
      chk("ill_rvalid", 32'(a_rsp_valid), 32'h1);
      chk("ill_sel",    32'(a_fpu_sel),   32'h0);
      chk("ill_irq",    32'(a_irq),       32'h1);
      check_rsp(1'b0, "ill");
      step();
      chk("ill_sel_after", 32'(a_fpu_sel), 32'h0);
      cmd_op = 4'd13; cmd_sub = 2'd0; va = 1'b1;
      qa.push_back('{32'h0, 5'd0, 1'b1, 1'b0});
      step();
      va = 1'b0;
      chk("ill13_rvalid", 32'(a_rsp_valid), 32'h1);
      check_rsp(1'b0, "ill13");
      step();

      // Backpressure with a second command pending.
      cmd_op = 4'd7; cmd_sub = 2'd0; va = 1'b1; rsp_ready = 1'b0;
      fpu_result = 32'h12345678; fpu_exc = 5'd0;
      qa.push_back('{32'h12345678, 5'd0, 1'b0, 1'b0});
      step();
      cmd_op = 4'd0;
      chk("bp_ready_issue", 32'(a_cmd_ready), 32'h0);
      step();
      fpu_result = 32'hDEADBEEF;
      for (int i = 0; i < 5; i++) begin
         chk("bp_ready",  32'(a_cmd_ready), 32'h0);
         chk("bp_rvalid", 32'(a_rsp_valid), 32'h1);
         chk("bp_data",   a_rsp_data,       32'h12345678);
         step();
      end
      rsp_ready = 1'b1;
      check_rsp(1'b0, "bp1");
      qa.push_back('{32'hDEADBEEF, 5'd0, 1'b0, 1'b0});
      step();
      chk("bp_ready_r1", 32'(a_cmd_ready), 32'h1);
      step();
      va = 1'b0;
      chk("bp_sel_issue", 32'(a_fpu_sel), 32'h001);
      step();
      chk("bp2_rvalid", 32'(a_rsp_valid), 32'h1);
      check_rsp(1'b0, "bp2");
      step();

      // Reset during WAIT.
      cmd_op = 4'd9; cmd_sub = 2'd1; cmd_frm = 3'd2; va = 1'b1;
      step();
      va = 1'b0;
      repeat (4) step();
      chk("mr_frm_t5",  32'(a_fpu_frm), 32'h2);
      chk("mr_op_t5",   32'(a_fpu_op),  32'h1);
      chk("mr_busy_t5", 32'(a_busy),    32'h1);
      rst = 1'b1;
      step();
      chk("mr_sel",    32'(a_fpu_sel),    32'h0);
      chk("mr_op",     32'(a_fpu_op),     32'h0);
      chk("mr_frm",    32'(a_fpu_frm),    32'h0);
      chk("mr_start",  32'(a_fpu_start),  32'h0);
      chk("mr_cancel", 32'(a_fpu_cancel), 32'h0);
      chk("mr_rvalid", 32'(a_rsp_valid),  32'h0);
      chk("mr_irq",    32'(a_irq),        32'h0);
      chk("mr_busy",   32'(a_busy),       32'h0);
      rst = 1'b0;
      step();
      chk("mr_ready", 32'(a_cmd_ready), 32'h1);
      div_done = 1'b1;
      step();
      div_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mr_late_rvalid", 32'(a_rsp_valid), 32'h0);
         chk("mr_late_busy",   32'(a_busy),      32'h0);
      end

      chk("qa_empty", 32'(qa.size()), 32'h0);
      chk("qb_empty", 32'(qb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
